// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/nibble_adder_slice.sv
// Combinational 4-bit ripple-carry adder made of full_adder cells.
module nibble_adder_slice
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[NIBBLE_W];

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract computed one nibble per cycle through a single shared slice.
// state | meaning
// IDLE  | ready for operands, outputs hold the last result
// RUN   | one slice pass per cycle, LSB nibble first
// DONE  | result valid, held until out_ready
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [NIBBLE_W-1:0] slice_a, slice_b, slice_sum;
    logic                slice_cout;

    assign slice_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
    assign slice_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

    nibble_adder_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtract is A + ~B + 1, so cin is replaced by the forced 1.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub ? 1'b1 : cin;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_cout;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    end

    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for the nibble-serial adder with a cycle-level reference model.
module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin, sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             busy;

    int tests = 0;
    int fails = 0;

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arithmetic result plus a countdown to result availability.
    function automatic logic [WIDTH:0] ref_result(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                  input logic c, input logic s);
        logic [WIDTH:0] r;
        if (s) r = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
        else   r = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
        return r;
    endfunction

    bit             m_init = 1'b0;
    int             m_cnt = 0;
    bit             m_valid = 1'b0;
    logic [WIDTH:0] m_pend = '0;
    logic [WIDTH-1:0] m_sum = '0;
    logic           m_cout = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_init  = 1'b1;
            m_cnt   = 0;
            m_valid = 1'b0;
            m_sum   = '0;
            m_cout  = 1'b0;
        end else if (m_init) begin
            if (m_cnt == 0 && !m_valid) begin
                if (in_valid) begin
                    m_pend = ref_result(a, b, cin, sub);
                    m_cnt  = NIBBLES;
                end
            end else if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_valid = 1'b1;
                    m_sum   = m_pend[WIDTH-1:0];
                    m_cout  = m_pend[WIDTH];
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("mdl_in_ready", 32'(in_ready), 32'(m_cnt == 0 && !m_valid));
            chk("mdl_out_valid", 32'(out_valid), 32'(m_valid));
            chk("mdl_busy", 32'(busy), 32'(m_cnt > 0 || m_valid));
            if (m_cnt == 0) begin
                chk("mdl_sum", 32'(sum), 32'(m_sum));
                chk("mdl_carry_out", 32'(carry_out), 32'(m_cout));
            end
        end
    end

    task automatic run_op(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_b,
                          input logic tcin, input logic tsub,
                          input logic [WIDTH-1:0] esum, input logic ecout,
                          input int hold, input bit noise);
        int lat;
        @(posedge clk); #1;
        a = ta; b = tb_b; cin = tcin; sub = tsub;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (noise) begin
                in_valid = ~in_valid;
                a = 16'hAAAA; b = 16'h5555; sub = ~sub;
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({name, "_latency"}, 32'(lat), 32'(NIBBLES));
        chk({name, "_sum"}, 32'(sum), 32'(esum));
        chk({name, "_carry"}, 32'(carry_out), 32'(ecout));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({name, "_hold_ready"}, 32'(in_ready), 32'd0);
            chk({name, "_hold_sum"}, 32'(sum), 32'(esum));
            chk({name, "_hold_carry"}, 32'(carry_out), 32'(ecout));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_release"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int acc_cnt, acc_cyc0, acc_cyc1, res_cnt, cyc;
        logic [WIDTH-1:0] res_sum [2];
        logic             res_c   [2];
        logic             rdy;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        rst = 1'b0;

        run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 0, 1'b0);
        run_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b0);
        run_op("add_cin", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 0, 1'b0);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 0, 1'b0);
        run_op("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 0, 1'b0);
        run_op("backpressure", 16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 3, 1'b0);
        run_op("run_noise", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 0, 1'b1);

        // Reset during the second RUN cycle.
        @(posedge clk); #1;
        a = 16'h7777; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 0, 1'b0);

        // Back-to-back with in_valid and out_ready held high.
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        acc_cnt = 0; res_cnt = 0; cyc = 0; acc_cyc0 = -1; acc_cyc1 = -1;
        while ((acc_cnt < 2 || res_cnt < 2) && cyc < 40) begin
            rdy = in_ready;
            @(posedge clk); #1;
            cyc++;
            if (rdy && in_valid) begin
                if (acc_cnt == 0) begin
                    acc_cyc0 = cyc;
                    a = 16'h8000; b = 16'h0001; sub = 1'b1;
                end else begin
                    acc_cyc1 = cyc;
                    in_valid = 1'b0;
                end
                acc_cnt++;
            end
            if (out_valid && res_cnt < 2) begin
                res_sum[res_cnt] = sum;
                res_c[res_cnt]   = carry_out;
                res_cnt++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_accepts", 32'(acc_cnt), 32'd2);
        chk("b2b_results", 32'(res_cnt), 32'd2);
        chk("b2b_interval", 32'(acc_cyc1 - acc_cyc0), 32'(NIBBLES + 2));
        if (res_cnt == 2) begin
            chk("b2b_sum0", 32'(res_sum[0]), 32'h3333);
            chk("b2b_carry0", 32'(res_c[0]), 32'd0);
            chk("b2b_sum1", 32'(res_sum[1]), 32'h7FFF);
            chk("b2b_carry1", 32'(res_c[1]), 32'd1);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
